// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, threshold flags and sticky errors.
// Supports non-power-of-two depth and a selectable fall-through read mode.
module sync_fifo_flags #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDR_WIDTH    = 3,
   parameter int FIFO_DEPTH    = 8,
   parameter int AFULL_THRESH  = 6,
   parameter int AEMPTY_THRESH = 2,
   parameter int FWFT          = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   input  logic                  clr_err,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] AF_C = CW'(AFULL_THRESH);
   localparam logic [CW-1:0] AE_C = CW'(AEMPTY_THRESH);
   localparam logic [ADDR_WIDTH-1:0] LAST_C = ADDR_WIDTH'(FIFO_DEPTH - 1);

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic                  udf_q, udf_d;
   logic                  wr_acc, rd_acc;

   always_comb begin
      full         = (count_q == DEPTH_C);
      empty        = (count_q == '0);
      almost_full  = (count_q >= AF_C);
      almost_empty = (count_q <= AE_C);
      wr_acc       = wr_en & ~full;
      rd_acc       = rd_en & ~empty;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_acc) begin
         wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1;
      end
      if (rd_acc) begin
         rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1;
      end
      unique case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      // set beats clear when both happen in one cycle
      ovf_d = (wr_en & full) | (ovf_q & ~clr_err);
      udf_d = (rd_en & empty) | (udf_q & ~clr_err);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   // storage is deliberately left unreset
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   assign count     = count_q;
   assign overflow  = ovf_q;
   assign underflow = udf_q;

   if (FWFT != 0) begin : g_fwft
      assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];
      assign rd_valid = ~empty;
   end else begin : g_std
      logic [DATA_WIDTH-1:0] rd_data_q;
      logic                  rd_valid_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
         end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
               rd_data_q <= mem_q[rd_ptr_q];
            end
         end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
   end

endmodule
